// File: rtl/fetch_pkg.sv
// Shared widths, response payload and parameter bounds for the instruction-fetch responder.
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W = 32;
  localparam int unsigned FETCH_DATA_W = 32;

  localparam int unsigned MEM_LAT_MIN  = 1;
  localparam int unsigned MEM_LAT_MAX  = 4;
  localparam int unsigned DEPTH_MAX    = 8;

  typedef struct packed {
    logic [FETCH_DATA_W-1:0] data;
    logic                    err;
  } fetch_resp_t;

endpackage

// File: rtl/inst_fetch_responder_if.sv
// Fetch-unit side of the request/dataOk protocol; master = fetch unit, slave = responder.
interface inst_fetch_responder_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              request_i;
  logic [ADDR_W-1:0] instAddr_i;
  logic              grant_o;
  logic              flush_i;
  logic              hold_i;
  logic              dataOk_o;
  logic [DATA_W-1:0] inst_o;
  logic              addrErr_o;

  modport master (
    output request_i, instAddr_i, flush_i, hold_i,
    input  grant_o, dataOk_o, inst_o, addrErr_o
  );

  modport slave (
    input  request_i, instAddr_i, flush_i, hold_i,
    output grant_o, dataOk_o, inst_o, addrErr_o
  );

endinterface

// File: rtl/resp_fifo.sv
// Synchronous circular FIFO with a synchronous clear; head word is visible combinationally.
module resp_fifo #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 33,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty,
  output logic             o_full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (i_push && !i_clear) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));

endmodule

// File: rtl/inst_fetch_responder.sv
// Instruction-fetch responder: issues requests to a fixed-latency SRAM, tracks them in a tag
// pipe, queues returned words and delivers them in order as dataOk pulses under credit control.
module inst_fetch_responder
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = FETCH_ADDR_W,
  parameter int unsigned DATA_W  = FETCH_DATA_W,
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  inst_fetch_responder_if.slave fetch,
  output logic                  mem_en_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  input  logic [DATA_W-1:0]     mem_rdata_i
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OCC_W = $clog2(MEM_LAT + DEPTH + 1);
  localparam int unsigned FW    = DATA_W + 1;

  if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
    $error("inst_fetch_responder: MEM_LAT out of range");
  end
  if (DEPTH < MEM_LAT + 1 || DEPTH > DEPTH_MAX) begin : g_bad_depth
    $error("inst_fetch_responder: DEPTH out of range");
  end

  logic [MEM_LAT-1:0] r_tag_vld;
  logic [MEM_LAT-1:0] r_tag_err;
  logic               r_data_ok;
  logic [DATA_W-1:0]  r_inst;
  logic               r_addr_err;

  logic               w_accept;
  logic               w_grant;
  logic               w_push;
  logic               w_pop;
  logic               w_fifo_empty;
  logic               w_fifo_full;
  logic [CNT_W-1:0]   w_fifo_cnt;
  logic [OCC_W-1:0]   w_inflight;
  logic [OCC_W-1:0]   w_occ;
  logic [FW-1:0]      w_push_data;
  logic [FW-1:0]      w_head;
  logic               w_last_err;

  // Credits: every accepted request owns a FIFO slot from issue until it is popped.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < int'(MEM_LAT); i++) begin
      w_inflight = w_inflight + OCC_W'(r_tag_vld[i]);
    end
  end

  assign w_occ      = w_inflight + OCC_W'(w_fifo_cnt);
  assign w_grant    = !reset && (w_occ < OCC_W'(DEPTH));
  assign w_accept   = fetch.request_i && w_grant;
  assign mem_en_o   = w_accept;
  assign mem_addr_o = reset ? '0 : {fetch.instAddr_i[ADDR_W-1:2], 2'b00};

  // A flush drops every older tag; the request accepted alongside it enters stage 0 untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tag_vld <= '0;
      r_tag_err <= '0;
    end else begin
      for (int i = int'(MEM_LAT) - 1; i > 0; i--) begin
        r_tag_vld[i] <= fetch.flush_i ? 1'b0 : r_tag_vld[i-1];
        r_tag_err[i] <= r_tag_err[i-1];
      end
      r_tag_vld[0] <= w_accept;
      r_tag_err[0] <= |fetch.instAddr_i[1:0];
    end
  end

  assign w_last_err  = r_tag_err[MEM_LAT-1];
  assign w_push      = r_tag_vld[MEM_LAT-1] && !fetch.flush_i;
  assign w_push_data = {(w_last_err ? '0 : mem_rdata_i), w_last_err};
  assign w_pop       = !w_fifo_empty && !fetch.hold_i && !fetch.flush_i;

  resp_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FW)
  ) u_resp_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_clear (fetch.flush_i),
    .i_push  (w_push),
    .i_wdata (w_push_data),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (w_fifo_cnt),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(w_push && w_fifo_full))
    else $error("inst_fetch_responder: push into full response FIFO");

  // Delivery register: instruction and error flag hold between pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_ok  <= 1'b0;
      r_inst     <= '0;
      r_addr_err <= 1'b0;
    end else begin
      r_data_ok <= w_pop;
      if (w_pop) begin
        r_inst     <= w_head[FW-1:1];
        r_addr_err <= w_head[0];
      end
    end
  end

  assign fetch.grant_o   = w_grant;
  assign fetch.dataOk_o  = r_data_ok;
  assign fetch.inst_o    = r_inst;
  assign fetch.addrErr_o = r_addr_err;

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Directed bench for inst_fetch_responder: table-driven single requests plus burst, hold,
// flush and reset sequences against a behavioural fixed-latency SRAM.
module tb_inst_fetch_responder;
  import fetch_pkg::*;

  localparam int unsigned L = 2;
  localparam int unsigned D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;

  inst_fetch_responder_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  inst_fetch_responder #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .MEM_LAT (L),
    .DEPTH   (D)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch       (bus),
    .mem_en_o    (mem_en),
    .mem_addr_o  (mem_addr),
    .mem_rdata_i (mem_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM contents: one special word, otherwise a tag built from the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0004) return 32'h0000_0013;
    return {16'hC0DE, a[15:0]};
  endfunction

  // Read data becomes valid L cycles after the address is sampled with mem_en_o.
  logic [31:0] mp [L];
  always @(posedge clk) begin
    mp[0] <= mem_addr;
    for (int i = 1; i < int'(L); i++) mp[i] <= mp[i-1];
  end
  assign mem_rdata = mem_word(mp[L-1]);

  typedef struct {
    fetch_resp_t rsp;
    int          at;
  } pulse_t;

  pulse_t got [$];

  always @(negedge clk) begin : mon
    pulse_t p;
    if (bus.dataOk_o === 1'b1) begin
      p.rsp.data = bus.inst_o;
      p.rsp.err  = bus.addrErr_o;
      p.at       = cyc;
      got.push_back(p);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] maddr;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  vec_t vt [6];

  initial begin
    int a;
    int h;
    int f;
    int acc;
    int gdrop;
    logic [31:0] nxt;

    vt[0] = '{32'h8000_0004, 32'h8000_0004, 32'h0000_0013, 1'b0};
    vt[1] = '{32'h0000_0006, 32'h0000_0004, 32'h0000_0000, 1'b1};
    vt[2] = '{32'h0000_0010, 32'h0000_0010, 32'hC0DE_0010, 1'b0};
    vt[3] = '{32'h1234_5679, 32'h1234_5678, 32'h0000_0000, 1'b1};
    vt[4] = '{32'h0000_FFFC, 32'h0000_FFFC, 32'hC0DE_FFFC, 1'b0};
    vt[5] = '{32'hDEAD_BEE3, 32'hDEAD_BEE0, 32'h0000_0000, 1'b1};

    reset          = 1'b1;
    bus.request_i  = 1'b0;
    bus.instAddr_i = '0;
    bus.flush_i    = 1'b0;
    bus.hold_i     = 1'b0;

    tick();
    chk("rst_dataok", bus.dataOk_o, 0);
    chk("rst_inst", bus.inst_o, 0);
    chk("rst_adderr", bus.addrErr_o, 0);
    chk("rst_grant", bus.grant_o, 0);
    chk("rst_mem_en", mem_en, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("rst_grant_after", bus.grant_o, 1);

    // Single isolated requests from the table.
    for (int k = 0; k < 6; k++) begin
      got.delete();
      bus.request_i  = 1'b1;
      bus.instAddr_i = vt[k].addr;
      #1;
      chk("v_grant", bus.grant_o, 1);
      chk("v_mem_en", mem_en, 1);
      chk("v_mem_addr", mem_addr, vt[k].maddr);
      tick();
      a = cyc;
      bus.request_i = 1'b0;
      repeat (6) tick();
      chk("v_pulses", got.size(), 1);
      if (got.size() > 0) begin
        chk("v_latency", got[0].at, a + 3);
        chk("v_inst", got[0].rsp.data, vt[k].inst);
        chk("v_err", got[0].rsp.err, vt[k].err);
      end
      chk("v_inst_held", bus.inst_o, vt[k].inst);
      chk("v_dataok_low", bus.dataOk_o, 0);
    end

    // Back-to-back burst of 8.
    got.delete();
    gdrop = 0;
    a = 0;
    bus.request_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.instAddr_i = 32'(k * 4);
      #1;
      if (bus.grant_o !== 1'b1) gdrop++;
      tick();
      if (k == 0) a = cyc;
    end
    bus.request_i = 1'b0;
    chk("b2b_grant_drops", gdrop, 0);
    repeat (12) tick();
    chk("b2b_count", got.size(), 8);
    for (int k = 0; k < 8; k++) begin
      if (k < got.size()) begin
        chk("b2b_data", got[k].rsp.data, {16'hC0DE, 16'(k * 4)});
        chk("b2b_at", got[k].at, a + 3 + k);
      end
    end

    // Hold with continuous requests: credits run out after DEPTH accepts.
    got.delete();
    bus.hold_i    = 1'b1;
    bus.request_i = 1'b1;
    acc = 0;
    nxt = 32'h40;
    repeat (10) begin
      bus.instAddr_i = nxt;
      #1;
      if (bus.grant_o === 1'b1) begin
        acc++;
        nxt = nxt + 32'd4;
      end
      tick();
    end
    #1;
    chk("hold_grant_low", bus.grant_o, 0);
    chk("hold_accepts", acc, 4);
    chk("hold_no_pulse", got.size(), 0);
    bus.request_i = 1'b0;
    h = cyc;
    bus.hold_i = 1'b0;
    repeat (6) tick();
    chk("hold_drain_count", got.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < got.size()) begin
        chk("hold_drain_data", got[k].rsp.data, 32'hC0DE_0040 + 32'(k * 4));
        chk("hold_drain_at", got[k].at, h + 1 + k);
      end
    end

    // Flush as the second response arrives, new request 0x100 in the same cycle.
    got.delete();
    bus.request_i  = 1'b1;
    bus.instAddr_i = 32'h200;
    tick();
    bus.instAddr_i = 32'h204;
    tick();
    bus.instAddr_i = 32'h208;
    tick();
    bus.instAddr_i = 32'h100;
    bus.flush_i    = 1'b1;
    #1;
    chk("fl_grant", bus.grant_o, 1);
    tick();
    f = cyc;
    bus.flush_i   = 1'b0;
    bus.request_i = 1'b0;
    chk("fl_dataok_after", bus.dataOk_o, 0);
    repeat (8) tick();
    chk("fl_count", got.size(), 1);
    if (got.size() > 0) begin
      chk("fl_data", got[0].rsp.data, 32'hC0DE_0100);
      chk("fl_at", got[0].at, f + 3);
    end

    // Asynchronous reset with the responder full of work.
    got.delete();
    bus.hold_i    = 1'b1;
    bus.request_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.instAddr_i = 32'h300 + 32'(k * 4);
      tick();
    end
    #1;
    chk("pre_rst_grant", bus.grant_o, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_dataok", bus.dataOk_o, 0);
    chk("arst_inst", bus.inst_o, 0);
    chk("arst_adderr", bus.addrErr_o, 0);
    chk("arst_grant", bus.grant_o, 0);
    chk("arst_mem_en", mem_en, 0);
    chk("arst_mem_addr", mem_addr, 0);
    bus.request_i = 1'b0;
    tick();
    tick();
    reset      = 1'b0;
    bus.hold_i = 1'b0;
    #1;
    chk("post_rst_grant", bus.grant_o, 1);
    repeat (10) tick();
    chk("post_rst_no_stale", got.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
